// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM duty meter and its divider.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned DUTY_W_DEF = 8;

  typedef enum logic {
    IDLE,
    MEAS
  } meas_state_e;

  typedef enum logic {
    DIV_IDLE,
    DIV_RUN
  } div_state_e;

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider: duty = floor({num, DUTY_W zeros} / den), one quotient
// bit per cycle over DUTY_W+1 cycles, saturating to all-ones when the quotient needs DUTY_W+1 bits.
module pwm_div
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_i,
  input  logic [CNT_W-1:0]  den_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DUTY_W-1:0] quo_o
);

  localparam int unsigned       ITER_W    = $clog2(DUTY_W + 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DUTY_W);

  div_state_e        state_q, state_d;
  logic [CNT_W:0]    rem_q, rem_d;
  logic [CNT_W-1:0]  den_q, den_d;
  logic              lsb_q, lsb_d;
  logic [DUTY_W-1:0] quo_q, quo_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [CNT_W+1:0]  trial;
  logic              fits;

  // The remainder starts as num>>1 so the first step brings in num[0]; the bits after are zeros.
  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    trial   = {rem_q, (iter_q == '0) ? lsb_q : 1'b0};
    fits    = (trial >= {2'b00, den_q});
    state_d = state_q;
    rem_d   = rem_q;
    den_d   = den_q;
    lsb_d   = lsb_q;
    quo_d   = quo_q;
    iter_d  = iter_q;
    done_o  = 1'b0;
    quo_o   = quo_q[DUTY_W-1] ? {DUTY_W{1'b1}} : {quo_q[DUTY_W-2:0], fits};
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_RUN;
          rem_d   = {2'b00, num_i[CNT_W-1:1]};
          lsb_d   = num_i[0];
          den_d   = den_i;
          quo_d   = '0;
          iter_d  = '0;
        end
      end
      DIV_RUN: begin
        rem_d  = fits ? (CNT_W+1)'(trial - {2'b00, den_q}) : trial[CNT_W:0];
        quo_d  = {quo_q[DUTY_W-2:0], fits};
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == LAST_ITER) begin
          state_d = DIV_IDLE;
          done_o  = 1'b1;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      den_q   <= '0;
      lsb_q   <= 1'b0;
      quo_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      lsb_q   <= lsb_d;
      quo_q   <= quo_d;
      iter_q  <= iter_d;
    end
  end

  assign busy_o = (state_q == DIV_RUN);

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and high time of an asynchronous PWM line (rise to rise, in clk50 cycles),
// converts them to a duty code and reports stuck lines once per stall.
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DUTY_W      = DUTY_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] PC_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;

  meas_state_e       state_q, state_d;
  logic [CNT_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]  hc_q, hc_d;
  logic              rep_done_q, rep_done_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  lat_period_q, lat_period_d;
  logic [CNT_W-1:0]  lat_high_q, lat_high_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              stuck_q, stuck_d;
  logic              overrun_q, overrun_d;

  logic              timeout;
  logic              rep_fire;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DUTY_W-1:0] div_quo;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  pwm_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk     (clk50),
    .rst_n   (rst_n),
    .start_i (div_start),
    .num_i   (hc_q),
    .den_i   (pc_q),
    .busy_o  (div_busy),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

  // A stall report waits while a divide is in flight so the older result comes out first.
  always_comb begin
    timeout   = !rise && (pc_q == PC_MAX) && ((state_q == MEAS) || !rep_done_q);
    rep_fire  = (timeout || pend_q) && !div_busy;
    div_start = rise && (state_q == MEAS) && !div_busy;
    overrun_d = rise && (state_q == MEAS) && div_busy;
    pend_d    = (timeout || pend_q) && !rep_fire;

    state_d      = state_q;
    pc_d         = pc_q;
    hc_d         = hc_q;
    rep_done_d   = rep_done_q;
    lat_period_d = lat_period_q;
    lat_high_d   = lat_high_q;

    if (rise) begin
      state_d    = MEAS;
      pc_d       = CNT_W'(1);
      hc_d       = CNT_W'(1);
      rep_done_d = 1'b0;
    end else if (timeout) begin
      state_d    = IDLE;
      rep_done_d = 1'b1;
    end else if (state_q == MEAS) begin
      pc_d = pc_q + CNT_W'(1);
      hc_d = hc_q + CNT_W'(s);
    end else if (pc_q != PC_MAX) begin
      pc_d = pc_q + CNT_W'(1);
    end

    if (div_start) begin
      lat_period_d = pc_q;
      lat_high_d   = hc_q;
    end

    valid_d  = div_done || rep_fire;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    stuck_d  = stuck_q;
    if (div_done) begin
      period_d = lat_period_q;
      high_d   = lat_high_q;
      duty_d   = div_quo;
      stuck_d  = 1'b0;
    end else if (rep_fire) begin
      period_d = '0;
      high_d   = '0;
      duty_d   = s ? {DUTY_W{1'b1}} : '0;
      stuck_d  = 1'b1;
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      s_d_q        <= 1'b0;
      state_q      <= IDLE;
      pc_q         <= '0;
      hc_q         <= '0;
      rep_done_q   <= 1'b0;
      pend_q       <= 1'b0;
      lat_period_q <= '0;
      lat_high_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q        <= s;
      state_q      <= state_d;
      pc_q         <= pc_d;
      hc_q         <= hc_d;
      rep_done_q   <= rep_done_d;
      pend_q       <= pend_d;
      lat_period_q <= lat_period_d;
      lat_high_q   <= lat_high_d;
      period_q     <= period_d;
      high_q       <= high_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      overrun_q    <= overrun_d;
    end
  end

  assign period_cnt = period_q;
  assign high_cnt   = high_q;
  assign duty       = duty_q;
  assign valid      = valid_q;
  assign stuck      = stuck_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Scoreboard bench for pwm_duty_meter: the driver predicts each result and its arrival cycle,
// the monitor pops and compares on the falling edge.
module tb_pwm_duty_meter;

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned DUTY_W = 8;
  localparam int unsigned MAXC   = (1 << CNT_W) - 1;
  localparam int unsigned MAXD   = (1 << DUTY_W) - 1;
  localparam int unsigned LAT    = DUTY_W + 2;

  typedef struct {
    int unsigned at;
    int unsigned period;
    int unsigned high;
    int unsigned duty;
    bit          stuck;
  } exp_t;

  logic              clk50 = 1'b0;
  logic              rst_n;
  logic              pwm_in;
  logic [CNT_W-1:0]  period_cnt;
  logic [CNT_W-1:0]  high_cnt;
  logic [DUTY_W-1:0] duty;
  logic              valid;
  logic              stuck;
  logic              overrun;

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .DUTY_W      (DUTY_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .duty       (duty),
    .valid      (valid),
    .stuck      (stuck),
    .overrun    (overrun)
  );

  always #5 clk50 = ~clk50;

  int unsigned cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  int unsigned ovq[$];
  exp_t e;

  bit          meas     = 1'b0;
  bit          lvl      = 1'b0;
  int unsigned last_t   = 0;
  int unsigned high_acc = 0;
  int unsigned div_free = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int unsigned duty_of(input int unsigned h, input int unsigned p);
    longint unsigned q;
    q = (64'(h) << DUTY_W) / 64'(p);
    return (q > MAXD) ? MAXD : int'(q);
  endfunction

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  // A line edge driven in slot c shows up as rise in DUT cycle c+2.
  task automatic rise_event();
    int unsigned t;
    t = cyc + 2;
    if (meas) begin
      if (t >= div_free) begin
        sb.push_back('{at: t + LAT, period: t - last_t, high: high_acc,
                       duty: duty_of(high_acc, t - last_t), stuck: 1'b0});
        div_free = t + LAT;
      end else begin
        ovq.push_back(t + 1);
      end
    end
    meas     = 1'b1;
    last_t   = t;
    high_acc = 0;
  endtask

  task automatic drive(input bit v, input int n);
    bit          rising;
    int unsigned x;
    rising = v && !lvl;
    pwm_in = v;
    lvl    = v;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && rising) begin
        rise_event();
      end else if (meas && (cyc + 2 - last_t == MAXC)) begin
        x = cyc + 2;
        sb.push_back('{at: (x < div_free) ? div_free + 1 : x + 1, period: 0, high: 0,
                       duty: v ? MAXD : 0, stuck: 1'b1});
        meas = 1'b0;
      end
      if (v) high_acc++;
      tick();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_period"},  period_cnt, 0);
    check({tag, "_high"},    high_cnt,   0);
    check({tag, "_duty"},    duty,       0);
    check({tag, "_valid"},   valid,      0);
    check({tag, "_stuck"},   stuck,      0);
    check({tag, "_overrun"}, overrun,    0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    sb.delete();
    ovq.delete();
    meas     = 1'b0;
    high_acc = 0;
    div_free = 0;
    tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk50) begin
    if (sb.size() != 0 && sb[0].at < cyc) begin
      check("valid_missing", cyc, sb[0].at);
      void'(sb.pop_front());
    end
    if (ovq.size() != 0 && ovq[0] < cyc) begin
      check("overrun_missing", cyc, ovq[0]);
      void'(ovq.pop_front());
    end
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("valid_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("valid_cycle", cyc, e.at);
        check("period_cnt", period_cnt, e.period);
        check("high_cnt", high_cnt, e.high);
        check("duty", duty, e.duty);
        check("stuck", stuck, e.stuck);
      end
    end
    if (overrun === 1'b1) begin
      if (ovq.size() == 0) check("overrun_unexpected", 1, 0);
      else check("overrun_cycle", cyc, ovq.pop_front());
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // 10 high / 30 low: period 40, high 10, duty 64
    repeat (4) begin
      drive(1'b1, 10);
      drive(1'b0, 30);
    end

    // 1/255 then 255/1: duty 1 then 255, period 256
    drive(1'b1, 1);
    drive(1'b0, 255);
    drive(1'b1, 255);
    drive(1'b0, 1);

    // stuck high, recovery, then stuck low
    drive(1'b1, 1100);
    drive(1'b0, 5);
    drive(1'b1, 4);
    drive(1'b0, 12);
    drive(1'b1, 2);
    drive(1'b0, 1100);

    // period 6: every second rise overruns
    repeat (8) begin
      drive(1'b1, 3);
      drive(1'b0, 3);
    end
    drive(1'b0, 20);

    // reset in the middle of a divide
    repeat (3) begin
      drive(1'b1, 4);
      drive(1'b0, 16);
    end
    drive(1'b1, 3);
    drive(1'b0, 2);
    do_reset();
    drive(1'b0, 5);
    repeat (3) begin
      drive(1'b1, 4);
      drive(1'b0, 16);
    end

    // generator-like 256-cycle frames with high time 255-d
    repeat (4) begin
      d = $urandom_range(0, 254);
      drive(1'b1, 255 - d);
      drive(1'b0, 1 + d);
    end
    drive(1'b1, 4);
    drive(1'b0, 30);

    check("sb_drained", sb.size(), 0);
    check("ovq_drained", ovq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
